// File: rtl/btb_pkg.sv
// Shared types for the branch target buffer: predictor mode encodings and table entry layout.
// The entry struct is sized for the widest supported PC (BTB_MAX_WORD bits). Narrower builds
// zero-extend into it, and synthesis sweeps the constant upper bits.
package btb_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC       = 2'd0,  // always predict fall-through
    MODE_COUNTER      = 2'd1,  // taken when hit and counter MSB set
    MODE_TAKEN_ON_HIT = 2'd2   // taken whenever the PC hits
  } btb_mode_e;

  localparam int BTB_MAX_WORD = 32;

  // The per-entry saturating counter lives in a sat_counter instance beside the entry.
  typedef struct packed {
    logic                    valid;
    logic [BTB_MAX_WORD-1:0] tag;
    logic [BTB_MAX_WORD-1:0] target;
  } btb_entry_t;

endpackage

// File: rtl/btb_predictor_sat_counter.sv
// Saturating up/down counter with a parallel load. Ports: clk, reset_n, inc, dec, load, load_val, count.
// Latency: 1 cycle (count updates at the rising edge after the request). No backpressure; a request is always accepted.
// Load has priority over inc/dec. Simultaneous inc and dec cancel. The count holds at 0 and at all-ones.
module sat_counter #(
  parameter int               WIDTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count
);

  // reset_n is active-high in this codebase despite its name.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      count <= RST_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (inc && !dec && (count != '1)) begin
      count <= count + WIDTH'(1);
    end else if (dec && !inc && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating counters and update statistics.
// Latency: lookup is combinational (0 cycles); updates and flushes take effect at the next rising edge. No backpressure.
// Ports: pc -> pred_pc/pred_hit lookup; upd_* resolved-branch update; upd_mispredict compare; flush_all; stat_* counters.
module btb_predictor
  import btb_pkg::*;
#(
  parameter int WORD_SIZE = 16,  // PC/target width, up to BTB_MAX_WORD
  parameter int ENTRIES   = 16,  // power of two, 2..256
  parameter int CTR_BITS  = 2,   // 1..3
  parameter int MODE      = 1    // btb_mode_e encoding
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WORD_SIZE-1:0] pc,
  output logic [WORD_SIZE-1:0] pred_pc,
  output logic                 pred_hit,
  input  logic                 upd_valid,
  input  logic [WORD_SIZE-1:0] upd_pc,
  input  logic [WORD_SIZE-1:0] upd_target,
  input  logic [WORD_SIZE-1:0] upd_pred_pc,
  input  logic                 upd_taken,
  input  logic                 flush_all,
  output logic                 upd_mispredict,
  output logic [15:0]          stat_updates,
  output logic [15:0]          stat_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = WORD_SIZE - IDX_W;
  localparam btb_mode_e MODE_E = btb_mode_e'(MODE[1:0]);
  // Reset leaves counters weakly not-taken. A fresh allocation starts weakly taken.
  localparam logic [CTR_BITS-1:0] CTR_RST  = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1 << (CTR_BITS - 1));

  // Flop-based storage so that the lookup read is asynchronous.
  btb_entry_t          tbl   [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q [ENTRIES];

  logic [IDX_W-1:0]     lk_idx;
  logic [TAG_W-1:0]     lk_tag;
  logic [IDX_W-1:0]     up_idx;
  logic [TAG_W-1:0]     up_tag;
  logic                 up_hit;
  logic                 pred_taken;
  logic [WORD_SIZE-1:0] actual_next;
  logic                 tbl_wr;

  assign lk_idx = pc[IDX_W-1:0];
  assign lk_tag = pc[WORD_SIZE-1:IDX_W];
  assign up_idx = upd_pc[IDX_W-1:0];
  assign up_tag = upd_pc[WORD_SIZE-1:IDX_W];

  // Both ports read the current table contents. A same-cycle update to the same entry is not forwarded.
  assign pred_hit = tbl[lk_idx].valid && (tbl[lk_idx].tag == BTB_MAX_WORD'(lk_tag));
  assign up_hit   = tbl[up_idx].valid && (tbl[up_idx].tag == BTB_MAX_WORD'(up_tag));

  always_comb begin
    pred_taken = 1'b0;
    case (MODE_E)
      MODE_STATIC:       pred_taken = 1'b0;
      MODE_COUNTER:      pred_taken = pred_hit && ctr_q[lk_idx][CTR_BITS-1];
      MODE_TAKEN_ON_HIT: pred_taken = pred_hit;
      default:           pred_taken = 1'b0;
    endcase
  end

  // Fall-through is pc+1, wrapping at the PC width.
  assign pred_pc = pred_taken ? tbl[lk_idx].target[WORD_SIZE-1:0] : (pc + WORD_SIZE'(1));

  assign actual_next    = upd_taken ? upd_target : (upd_pc + WORD_SIZE'(1));
  assign upd_mispredict = upd_valid && (upd_pred_pc != actual_next);

  // A taken update either refreshes the hit entry's target or allocates over whatever aliases there.
  // A not-taken miss leaves the table alone. A flush overrides any coincident update.
  assign tbl_wr = upd_valid && upd_taken && !flush_all;

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl[i] <= '0;
      end
    end else if (flush_all) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl[i].valid <= 1'b0;
      end
    end else if (tbl_wr) begin
      tbl[up_idx].valid  <= 1'b1;
      tbl[up_idx].tag    <= BTB_MAX_WORD'(up_tag);
      tbl[up_idx].target <= BTB_MAX_WORD'(upd_target);
    end
  end

  for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
    logic sel;
    assign sel = upd_valid && !flush_all && (up_idx == IDX_W'(i));

    sat_counter #(
      .WIDTH   (CTR_BITS),
      .RST_VAL (CTR_RST)
    ) u_ctr (
      .clk      (clk),
      .reset_n  (reset_n),
      .inc      (sel && up_hit && upd_taken),
      .dec      (sel && up_hit && !upd_taken),
      .load     (sel && !up_hit && upd_taken),
      .load_val (CTR_WEAK),
      .count    (ctr_q[i])
    );
  end

  // Statistics keep counting through a flush.
  sat_counter #(
    .WIDTH   (16),
    .RST_VAL (16'h0000)
  ) u_stat_upd (
    .clk      (clk),
    .reset_n  (reset_n),
    .inc      (upd_valid),
    .dec      (1'b0),
    .load     (1'b0),
    .load_val (16'h0000),
    .count    (stat_updates)
  );

  sat_counter #(
    .WIDTH   (16),
    .RST_VAL (16'h0000)
  ) u_stat_misp (
    .clk      (clk),
    .reset_n  (reset_n),
    .inc      (upd_mispredict),
    .dec      (1'b0),
    .load     (1'b0),
    .load_val (16'h0000),
    .count    (stat_mispredicts)
  );

endmodule

// File: tb/tb_btb_predictor.sv
// Directed bench for btb_predictor. Three instances (MODE 1, 0, 2) share one stimulus stream.
// Inputs change at the falling edge. Outputs are sampled 1 time unit later, away from the rising edge.
module tb_btb_predictor;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [15:0] pc = 16'h0010;
  logic        upd_valid = 1'b0;
  logic [15:0] upd_pc = 16'h0000;
  logic [15:0] upd_target = 16'h0000;
  logic [15:0] upd_pred_pc = 16'h0000;
  logic        upd_taken = 1'b0;
  logic        flush_all = 1'b0;

  logic [15:0] pred_pc, pred_pc_m0, pred_pc_m2;
  logic        pred_hit, pred_hit_m0, pred_hit_m2;
  logic        upd_mispredict, misp_m0, misp_m2;
  logic [15:0] stat_updates, stat_mispredicts;
  logic [15:0] su_m0, sm_m0, su_m2, sm_m2;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  btb_predictor #(.WORD_SIZE(16), .ENTRIES(16), .CTR_BITS(2), .MODE(1)) dut (
    .clk(clk), .reset_n(reset_n), .pc(pc), .pred_pc(pred_pc), .pred_hit(pred_hit),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_pred_pc(upd_pred_pc),
    .upd_taken(upd_taken), .flush_all(flush_all), .upd_mispredict(upd_mispredict),
    .stat_updates(stat_updates), .stat_mispredicts(stat_mispredicts));

  btb_predictor #(.WORD_SIZE(16), .ENTRIES(16), .CTR_BITS(2), .MODE(0)) dut_m0 (
    .clk(clk), .reset_n(reset_n), .pc(pc), .pred_pc(pred_pc_m0), .pred_hit(pred_hit_m0),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_pred_pc(upd_pred_pc),
    .upd_taken(upd_taken), .flush_all(flush_all), .upd_mispredict(misp_m0),
    .stat_updates(su_m0), .stat_mispredicts(sm_m0));

  btb_predictor #(.WORD_SIZE(16), .ENTRIES(16), .CTR_BITS(2), .MODE(2)) dut_m2 (
    .clk(clk), .reset_n(reset_n), .pc(pc), .pred_pc(pred_pc_m2), .pred_hit(pred_hit_m2),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_pred_pc(upd_pred_pc),
    .upd_taken(upd_taken), .flush_all(flush_all), .upd_mispredict(misp_m2),
    .stat_updates(su_m2), .stat_mispredicts(sm_m2));

  // Stimulus helper: present one update. Call it just after a falling edge.
  task automatic set_upd(input logic v, input logic [15:0] p, input logic [15:0] tgt,
                         input logic [15:0] pp, input logic tk);
    upd_valid   = v;
    upd_pc      = p;
    upd_target  = tgt;
    upd_pred_pc = pp;
    upd_taken   = tk;
  endtask

  task automatic test_reset;
    @(negedge clk);
    pc = 16'h0010;
    // This update arrives while reset is held, so it must be discarded.
    set_upd(1'b1, 16'h0013, 16'h0040, 16'h0014, 1'b1);
    #1;
    checks++; if (pred_hit !== 1'b0) begin fails++; $display("FAIL rst_hit: got %b expected 0", pred_hit); end
    checks++; if (pred_pc !== 16'h0011) begin fails++; $display("FAIL rst_pred_pc: got %h expected 0011", pred_pc); end
    checks++; if (upd_mispredict !== 1'b1) begin fails++; $display("FAIL rst_misp: got %b expected 1", upd_mispredict); end
    @(negedge clk);
    reset_n = 1'b0;
    set_upd(1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    pc = 16'h0013;
    #1;
    checks++; if (stat_updates !== 16'h0000) begin fails++; $display("FAIL rst_stat_upd: got %h expected 0000", stat_updates); end
    checks++; if (stat_mispredicts !== 16'h0000) begin fails++; $display("FAIL rst_stat_misp: got %h expected 0000", stat_mispredicts); end
    checks++; if (pred_hit !== 1'b0) begin fails++; $display("FAIL rst_discard_hit: got %b expected 0", pred_hit); end
    checks++; if (dut.ctr_q[3] !== 2'd1) begin fails++; $display("FAIL rst_ctr: got %0d expected 1", dut.ctr_q[3]); end
  endtask

  task automatic test_alloc;
    @(negedge clk);
    pc = 16'h0013;
    set_upd(1'b1, 16'h0013, 16'h0040, 16'h0014, 1'b1);
    #1;
    // The entry is not written until the edge, so the same-cycle lookup still misses.
    checks++; if (pred_hit !== 1'b0) begin fails++; $display("FAIL alloc_nobypass: got %b expected 0", pred_hit); end
    checks++; if (upd_mispredict !== 1'b1) begin fails++; $display("FAIL alloc_misp: got %b expected 1", upd_mispredict); end
    @(negedge clk);
    set_upd(1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    #1;
    checks++; if (pred_hit !== 1'b1) begin fails++; $display("FAIL alloc_hit: got %b expected 1", pred_hit); end
    checks++; if (pred_pc !== 16'h0040) begin fails++; $display("FAIL alloc_pred_pc: got %h expected 0040", pred_pc); end
    checks++; if (dut.ctr_q[3] !== 2'd2) begin fails++; $display("FAIL alloc_ctr: got %0d expected 2", dut.ctr_q[3]); end
    checks++; if (stat_updates !== 16'd1) begin fails++; $display("FAIL alloc_stat_upd: got %0d expected 1", stat_updates); end
    checks++; if (stat_mispredicts !== 16'd1) begin fails++; $display("FAIL alloc_stat_misp: got %0d expected 1", stat_mispredicts); end
    checks++; if (pred_hit_m0 !== 1'b1) begin fails++; $display("FAIL m0_hit: got %b expected 1", pred_hit_m0); end
    checks++; if (pred_pc_m0 !== 16'h0014) begin fails++; $display("FAIL m0_pred_pc: got %h expected 0014", pred_pc_m0); end
    checks++; if (pred_pc_m2 !== 16'h0040) begin fails++; $display("FAIL m2_pred_pc: got %h expected 0040", pred_pc_m2); end
  endtask

  task automatic test_not_taken;
    logic [1:0]  exp_ctr  [3] = '{2'd1, 2'd0, 2'd0};
    logic [15:0] exp_pp   [3] = '{16'h0040, 16'h0014, 16'h0014};
    logic        exp_misp [3] = '{1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      set_upd(1'b1, 16'h0013, 16'h0000, exp_pp[k], 1'b0);
      #1;
      checks++; if (upd_mispredict !== exp_misp[k]) begin fails++; $display("FAIL nt_misp[%0d]: got %b expected %b", k, upd_mispredict, exp_misp[k]); end
      @(negedge clk);
      set_upd(1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
      #1;
      checks++; if (dut.ctr_q[3] !== exp_ctr[k]) begin fails++; $display("FAIL nt_ctr[%0d]: got %0d expected %0d", k, dut.ctr_q[3], exp_ctr[k]); end
      checks++; if (pred_pc !== 16'h0014) begin fails++; $display("FAIL nt_pred_pc[%0d]: got %h expected 0014", k, pred_pc); end
      checks++; if (pred_hit !== 1'b1) begin fails++; $display("FAIL nt_hit[%0d]: got %b expected 1", k, pred_hit); end
    end
    // Taken-on-hit ignores the counter, so the old target is still predicted.
    checks++; if (pred_pc_m2 !== 16'h0040) begin fails++; $display("FAIL m2_nt_pred_pc: got %h expected 0040", pred_pc_m2); end
    checks++; if (stat_updates !== 16'd4) begin fails++; $display("FAIL nt_stat_upd: got %0d expected 4", stat_updates); end
    checks++; if (stat_mispredicts !== 16'd2) begin fails++; $display("FAIL nt_stat_misp: got %0d expected 2", stat_mispredicts); end
  endtask

  task automatic test_taken_hit;
    logic [1:0]  exp_ctr [2] = '{2'd1, 2'd2};
    logic [15:0] exp_pp  [2] = '{16'h0014, 16'h0055};
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      set_upd(1'b1, 16'h0013, 16'h0055, 16'h0014, 1'b1);
      @(negedge clk);
      set_upd(1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
      #1;
      checks++; if (dut.ctr_q[3] !== exp_ctr[k]) begin fails++; $display("FAIL th_ctr[%0d]: got %0d expected %0d", k, dut.ctr_q[3], exp_ctr[k]); end
      checks++; if (pred_pc !== exp_pp[k]) begin fails++; $display("FAIL th_pred_pc[%0d]: got %h expected %h", k, pred_pc, exp_pp[k]); end
      checks++; if (pred_pc_m2 !== 16'h0055) begin fails++; $display("FAIL th_m2_pred_pc[%0d]: got %h expected 0055", k, pred_pc_m2); end
    end
    checks++; if (stat_mispredicts !== 16'd4) begin fails++; $display("FAIL th_stat_misp: got %0d expected 4", stat_mispredicts); end
  endtask

  task automatic test_alias;
    @(negedge clk);
    pc = 16'h0023;
    #1;
    checks++; if (pred_hit !== 1'b0) begin fails++; $display("FAIL alias_hit: got %b expected 0", pred_hit); end
    checks++; if (pred_pc !== 16'h0024) begin fails++; $display("FAIL alias_pred_pc: got %h expected 0024", pred_pc); end
    set_upd(1'b1, 16'h0023, 16'h0077, 16'h0024, 1'b1);
    @(negedge clk);
    set_upd(1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    #1;
    checks++; if (pred_pc !== 16'h0077) begin fails++; $display("FAIL alias_new_pred_pc: got %h expected 0077", pred_pc); end
    checks++; if (dut.ctr_q[3] !== 2'd2) begin fails++; $display("FAIL alias_ctr: got %0d expected 2", dut.ctr_q[3]); end
    pc = 16'h0013;
    #1;
    checks++; if (pred_hit !== 1'b0) begin fails++; $display("FAIL alias_old_hit: got %b expected 0", pred_hit); end
    checks++; if (pred_pc !== 16'h0014) begin fails++; $display("FAIL alias_old_pred_pc: got %h expected 0014", pred_pc); end
  endtask

  task automatic test_wrap;
    @(negedge clk);
    pc = 16'hFFFF;
    set_upd(1'b1, 16'hFFFF, 16'h1234, 16'h0000, 1'b0);
    #1;
    checks++; if (pred_pc !== 16'h0000) begin fails++; $display("FAIL wrap_pred_pc: got %h expected 0000", pred_pc); end
    checks++; if (upd_mispredict !== 1'b0) begin fails++; $display("FAIL wrap_misp: got %b expected 0", upd_mispredict); end
    @(negedge clk);
    set_upd(1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    #1;
    // A not-taken miss must not allocate an entry or touch the counter.
    checks++; if (pred_hit !== 1'b0) begin fails++; $display("FAIL wrap_noalloc: got %b expected 0", pred_hit); end
    checks++; if (dut.ctr_q[15] !== 2'd1) begin fails++; $display("FAIL wrap_ctr: got %0d expected 1", dut.ctr_q[15]); end
    checks++; if (stat_updates !== 16'd8) begin fails++; $display("FAIL wrap_stat_upd: got %0d expected 8", stat_updates); end
  endtask

  task automatic test_flush;
    @(negedge clk);
    pc = 16'h0023;
    flush_all = 1'b1;
    set_upd(1'b1, 16'h0023, 16'h0099, 16'h0024, 1'b1);
    #1;
    checks++; if (upd_mispredict !== 1'b1) begin fails++; $display("FAIL flush_misp: got %b expected 1", upd_mispredict); end
    @(negedge clk);
    flush_all = 1'b0;
    set_upd(1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    #1;
    checks++; if (pred_hit !== 1'b0) begin fails++; $display("FAIL flush_hit: got %b expected 0", pred_hit); end
    checks++; if (pred_hit_m2 !== 1'b0) begin fails++; $display("FAIL flush_m2_hit: got %b expected 0", pred_hit_m2); end
    checks++; if (pred_pc !== 16'h0024) begin fails++; $display("FAIL flush_pred_pc: got %h expected 0024", pred_pc); end
    checks++; if (dut.ctr_q[3] !== 2'd2) begin fails++; $display("FAIL flush_ctr: got %0d expected 2", dut.ctr_q[3]); end
    checks++; if (stat_updates !== 16'd9) begin fails++; $display("FAIL flush_stat_upd: got %0d expected 9", stat_updates); end
    checks++; if (stat_mispredicts !== 16'd6) begin fails++; $display("FAIL flush_stat_misp: got %0d expected 6", stat_mispredicts); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    pc = 16'h0031;
    set_upd(1'b1, 16'h0031, 16'h0100, 16'h0032, 1'b1);
    @(negedge clk);
    set_upd(1'b1, 16'h0042, 16'h0200, 16'h0043, 1'b1);
    #1;
    checks++; if (pred_pc !== 16'h0100) begin fails++; $display("FAIL b2b_first: got %h expected 0100", pred_pc); end
    @(negedge clk);
    set_upd(1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    pc = 16'h0042;
    #1;
    checks++; if (pred_pc !== 16'h0200) begin fails++; $display("FAIL b2b_second: got %h expected 0200", pred_pc); end
    checks++; if (stat_updates !== 16'd11) begin fails++; $display("FAIL b2b_stat_upd: got %0d expected 11", stat_updates); end
    checks++; if (stat_mispredicts !== 16'd8) begin fails++; $display("FAIL b2b_stat_misp: got %0d expected 8", stat_mispredicts); end
  endtask

  task automatic test_stat_saturate;
    // Correctly predicted not-taken misses: they only bump stat_updates.
    @(negedge clk);
    set_upd(1'b1, 16'hFFFF, 16'h0000, 16'h0000, 1'b0);
    for (int k = 0; k < 65530; k++) @(negedge clk);
    set_upd(1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    #1;
    checks++; if (stat_updates !== 16'hFFFF) begin fails++; $display("FAIL sat_stat_upd: got %h expected ffff", stat_updates); end
    checks++; if (stat_mispredicts !== 16'd8) begin fails++; $display("FAIL sat_stat_misp: got %0d expected 8", stat_mispredicts); end
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_not_taken();
    test_taken_hit();
    test_alias();
    test_wrap();
    test_flush();
    test_back_to_back();
    test_stat_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/btb_predictor.md
BTB_PREDICTOR -- requirements
Module: btb_predictor

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16: PC/target width.
REQ-002 SHALL have parameter ENTRIES, default 16: table depth; power of two, 2..256; IDX_W = log2(ENTRIES).
REQ-003 SHALL have parameter CTR_BITS, default 2: saturating counter width, 1..3.
REQ-004 SHALL have parameter MODE, default 1: 0 = static not-taken, 1 = counter-based, 2 = taken-on-hit.
REQ-005 SHALL have port clk, input, 1: clock; all state updates on the rising edge.
REQ-006 SHALL have port reset_n, input, 1: reset; asynchronous, active-high.
REQ-007 SHALL have port pc, input, WORD_SIZE: fetch PC to look up.
REQ-008 SHALL have port pred_pc, output, WORD_SIZE: predicted next fetch PC.
REQ-009 SHALL have port pred_hit, output, 1: pc matched a valid entry.
REQ-010 SHALL have port upd_valid, input, 1: resolved branch/jump update strobe.
REQ-011 SHALL have ports upd_pc, upd_target and upd_pred_pc, input, WORD_SIZE each: resolved instruction PC, actual target, and the prediction made at its fetch.
REQ-012 SHALL have port upd_taken, input, 1: the resolved control transfer was taken.
REQ-013 SHALL have port flush_all, input, 1: invalidate the whole table.
REQ-014 SHALL have port upd_mispredict, output, 1: combinational mispredict flag for the current update.
REQ-015 SHALL have ports stat_updates and stat_mispredicts, output, 16 each: saturating event counters.

Function
REQ-016 Each entry SHALL hold valid, tag = pc[WORD_SIZE-1:IDX_W], target (WORD_SIZE) and counter (CTR_BITS); index = pc[IDX_W-1:0].
REQ-017 Lookup SHALL be combinational with zero latency: pred_hit = valid && tag match.
REQ-018 Predicted-taken SHALL be: MODE 0 never; MODE 1 hit && counter MSB = 1; MODE 2 hit.
REQ-019 pred_pc SHALL be target when predicted-taken, else pc+1 modulo 2^WORD_SIZE, so 0xFFFF wraps to 0x0000.
REQ-020 pred_hit SHALL be reported in all modes.
REQ-021 actual_next SHALL be upd_taken ? upd_target : upd_pc+1, wrapping modulo 2^WORD_SIZE.
REQ-022 upd_mispredict SHALL be upd_valid && (upd_pred_pc != actual_next), else 0.
REQ-023 On upd_valid with an upd_pc hit, the counter SHALL increment if taken and decrement if not taken, saturating at 0 and 2^CTR_BITS-1.
REQ-024 On upd_valid with an upd_pc hit and taken, the entry target SHALL be overwritten with upd_target.
REQ-025 On upd_valid with an upd_pc miss and taken, the module SHALL allocate (replacing any aliased entry): valid=1, tag, target, counter = 2^(CTR_BITS-1) (weakly taken).
REQ-026 On upd_valid with an upd_pc miss and not taken, no table state SHALL change.
REQ-027 Each upd_valid cycle SHALL increment stat_updates, and SHALL increment stat_mispredicts when upd_mispredict = 1; both saturate at 0xFFFF.
REQ-028 Lookup and update to the same index in the same cycle SHALL return pre-update contents; there is no bypass.
REQ-029 flush_all SHALL clear all valid bits at the next edge, leaving counters and targets unchanged; coincident with upd_valid, flush wins for the table, but statistics still count.
REQ-030 All table and statistics state changes SHALL occur only at clk rising edges.

Reset
REQ-031 While reset_n = 1, all valid bits SHALL be 0, counters 2^(CTR_BITS-1)-1, targets 0, stat_updates = stat_mispredicts = 0.
REQ-032 Outputs during reset SHALL be pred_hit = 0, pred_pc = pc+1, and upd_mispredict per REQ-022.
REQ-033 Reset asserted mid-operation SHALL discard any update in that cycle; normal operation resumes on the first edge after deassertion.

Structure
REQ-034 A shared package btb_pkg SHALL hold the MODE encodings (MODE_STATIC, MODE_COUNTER, MODE_TAKEN_ON_HIT) and the entry struct typedef.
REQ-035 One sub-module sat_counter SHALL be used: parameter WIDTH, inputs inc/dec/load/load_val, saturating output.
REQ-036 Table storage SHALL be flops, not an inferred RAM, because lookup is asynchronous.

Verification (ENTRIES=16, CTR_BITS=2, MODE=1 unless stated)
REQ-037 Reset, then pc=0x0010 -> pred_hit=0, pred_pc=0x0011; stats 0.
REQ-038 Update upd_pc=0x0013, target 0x0040, taken; next cycle pc=0x0013 -> pred_hit=1, counter=2, pred_pc=0x0040.
REQ-039 Two not-taken updates to 0x0013, then a third -> counter goes 1 then 0 and stays 0; pred_pc=0x0014, pred_hit=1.
REQ-040 Entry for 0x0013 present, pc=0x0023 (same index) -> pred_hit=0, pred_pc=0x0024; a taken update for 0x0023 replaces it, and 0x0013 then misses.
REQ-041 pc=0xFFFF miss -> pred_pc=0x0000. Update upd_pc=0x0013, upd_pred_pc=0x0014, taken to 0x0040 -> upd_mispredict=1, stat_mispredicts+1; flush_all with upd_valid -> table empty, stat_updates+1.
REQ-042 MODE=0 with a valid entry -> pred_hit=1, pred_pc=pc+1; MODE=2 -> pred_pc=target regardless of counter.
